// File: rtl/dac_sample_feeder.sv
// Stereo FIFO between the synthesis pipeline and the DAC transmitter.
// Presents one settled pair per frame, advancing on each lrclk left-to-right edge.
module dac_sample_feeder #(
    parameter int WIDTH       = 24,
    parameter int DEPTH       = 8,
    parameter int START_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_left,
    input  logic [WIDTH-1:0]         in_right,
    input  logic                     lrclk,
    output logic [WIDTH-1:0]         left_data,
    output logic [WIDTH-1:0]         right_data,
    output logic                     dac_enable,
    output logic                     underrun,
    input  logic                     clear_underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_PREFILL, S_RUN} state_t;

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_lrclk_q;
    state_t             r_state;
    logic [WIDTH-1:0]   r_left;
    logic [WIDTH-1:0]   r_right;
    logic               r_enable;
    logic               r_underrun;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_tick;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_tick  = r_lrclk_q && !lrclk;
    assign w_pop   = w_tick && !w_empty;

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_left, in_right};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lrclk_q  <= 1'b1;
            r_state    <= S_PREFILL;
            r_left     <= '0;
            r_right    <= '0;
            r_enable   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_lrclk_q <= lrclk;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // An empty frame mutes the outputs; a same-cycle push is not bypassed.
            if (w_tick) begin
                if (!w_empty) begin
                    {r_left, r_right} <= r_mem[r_rd_ptr];
                end else begin
                    r_left  <= '0;
                    r_right <= '0;
                end
            end

            if (w_tick && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun) begin
                r_underrun <= 1'b0;
            end

            case (r_state)
                S_PREFILL: begin
                    r_enable <= 1'b0;
                    if (r_count >= CW'(START_LEVEL)) begin
                        r_state  <= S_RUN;
                        r_enable <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_enable <= 1'b1;
                end
                default: begin
                    r_state  <= S_PREFILL;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = !w_full;
    assign level      = r_count;
    assign left_data  = r_left;
    assign right_data = r_right;
    assign dac_enable = r_enable;
    assign underrun   = r_underrun;

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Stereo sample buffer directly upstream of the DAC transmitter, in the transmitter's bit-clock domain. The block accepts left/right sample pairs from the synthesis pipeline through a valid/ready handshake and stores them in a small FIFO. It presents one stable pair on `left_data`/`right_data` per frame, advancing on every left-to-right transition of the transmitter's `lrclk`, so the transmitter always latches a settled pair at its frame load point. It also gates the transmitter `enable` until the FIFO is prefilled, and flags underruns.

## Interface
- `WIDTH`, 24: sample width per channel, in bits.
- `DEPTH`, 8: FIFO depth in stereo pairs; must be a power of two and at least 2.
- `START_LEVEL`, 4: fill level, in pairs, required before `dac_enable` first rises; valid range 1..`DEPTH`.

- `clk`  in  1: bit clock, the same clock that drives the transmitter. All logic runs on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: producer offers a pair on this cycle.
- `in_ready`  out  1: FIFO can accept a pair; equals `!full`.
- `in_left`  in  `WIDTH`: left sample offered by the producer.
- `in_right`  in  `WIDTH`: right sample offered by the producer.
- `lrclk`  in  1: word-select line from the transmitter (1 = left). The transmitter drives it from its falling-edge logic.
- `left_data`  out  `WIDTH`: left sample presented to the transmitter.
- `right_data`  out  `WIDTH`: right sample presented to the transmitter.
- `dac_enable`  out  1: drives the transmitter's `enable` input.
- `underrun`  out  1: sticky flag; set when a frame is needed and the FIFO is empty.
- `clear_underrun`  in  1: clears `underrun`.
- `level`  out  `$clog2(DEPTH)+1`: number of pairs currently stored, 0..`DEPTH`.

## Operation
- The FIFO is a circular buffer with write pointer, read pointer and count registers. Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- Push: occurs when `in_valid && in_ready`. The pair is written at the write pointer, the write pointer increments, and the count increments.
- A push offered while full is ignored. `in_ready` is low in that case, and the producer must hold its data.
- `lrclk_q` is a rising-edge register of `lrclk`.
- Frame tick: `tick = lrclk_q && !lrclk`. This is the left-to-right transition, i.e. mid-frame, after the transmitter has already loaded the current pair.
- Pop on tick, FIFO not empty: the pair at the read pointer is registered into `left_data`/`right_data`, the read pointer increments, and the count decrements.
- Pop on tick, FIFO empty:
  - `left_data`/`right_data` are loaded with 0 (mute).
  - `underrun` is set to 1.
  - Pointers and count are unchanged.
  - There is no bypass: a push in the same cycle is stored normally, but that pair is not forwarded to the outputs in that cycle.
- Push and non-empty pop in the same cycle: both take effect and the count is unchanged. This is legal even when full, because `in_ready` is low when full, so no push occurs then.
- `left_data`/`right_data` change only on a tick or on reset.
- Enable control, two states:
  - PREFILL: `dac_enable` = 0. Move to RUN when `level >= START_LEVEL`, evaluated on the registered count.
  - RUN: `dac_enable` = 1. The block stays in RUN until reset. An underrun does not return it to PREFILL.
- While `dac_enable` = 0 the transmitter holds `lrclk` = 1, so no tick can occur in PREFILL.
- `underrun`: set on an empty pop and cleared by `clear_underrun`. If both happen in the same cycle, set wins.
- `level` equals the count register.

## Timing
- Reset (`reset_n` = 0 at a rising edge) produces:
  - count, both pointers, `left_data`, `right_data` = 0
  - `lrclk_q` = 1
  - `underrun` = 0
  - `dac_enable` = 0, state PREFILL
  - `in_ready` = 1, `level` = 0
- FIFO memory contents are not reset.
- Reset mid-operation discards all stored pairs and drops `dac_enable` on the next edge. The transmitter then returns to idle with `lrclk` = 1.
- Push latency: a pair accepted at edge N is counted in `level` after edge N. It is eligible for a pop at edge N+1 or later.
- Tick latency: `lrclk` falls at a falling edge, and the tick is detected at the next rising edge.
  - Outputs update at that rising edge.
  - The transmitter loads them at the frame wrap, `WIDTH` clocks later, giving about `WIDTH` cycles of settling margin.
- Pop rate is exactly one per `2*WIDTH` clocks while in RUN. The producer must sustain at least that average rate.
- `dac_enable` rises at the rising edge after `level` first reaches `START_LEVEL`.
- `in_ready`, `level` and `dac_enable` are all registered-derived; there are no combinational paths from `in_valid` to `in_ready`.

## Test plan
- Prefill: reset, then push pairs (1,−1), (2,−2), (3,−3), (4,−4) back-to-back. Required: `dac_enable` = 0 through the 4th push and rises on the following edge; `level` reads 4.
- Ordered stream:
  - Setup: drive a transmitter model; push pairs k = 1..20 at one per 48 clocks after prefill.
  - Required: `left_data` = k and `right_data` = −k in order, each stable across the transmitter's load edge.
  - Required: no underrun; `level` oscillates between 3 and 4.
- Full/back-pressure: push 10 pairs without ticks with `DEPTH` = 8. Required: `in_ready` falls after the 8th push; pairs 9–10 are not stored; `level` = 8; later pops return 1..8 in order.
- Underrun:
  - Setup: prefill 4 pairs, then stop pushing.
  - Required: after the 4th tick `level` = 0; the 5th tick sets `left_data`/`right_data` = 0 and `underrun` = 1, and `underrun` stays 1.
  - Required: `clear_underrun` pulsed with no tick clears it; pulsed together with an empty tick, it leaves it at 1.
- Simultaneous push/pop and wrap: with `level` = 3, assert push on the tick cycle for 12 consecutive frames. Required: `level` stays 3, pointers wrap past 7, and order is preserved.
- Reset mid-stream: assert `reset_n` = 0 for one edge with `level` = 5. Required: next edge has `level` = 0, `dac_enable` = 0, outputs 0, `underrun` = 0; after prefilling again, the stream resumes from the new data.
